seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Receive side of the multiplexed seven-segment display bus. Samples the active-low segment lines and digit strobes, waits for each pattern to be stable, decodes it back to a 4-bit digit value, and assembles one full frame of `NDIG` digits. The frame is presented on a valid/ready output, so display-driving logic can be checked or looped back in-system.

## Interface
- `NDIG`, 8: number of multiplexed digits; range 2..8.
- `STABLE`, 4: consecutive identical samples required before a digit is committed; range 2..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `seg_i` in 7: segment lines, active-low (0 = lit); bit0 = a … bit6 = g.
- `an_i` in `NDIG`: digit strobes, active-low, one-hot-low when valid.
- `out_valid` out 1: a frame is held on the outputs.
- `out_ready` in 1: consumer accepts the frame.
- `out_digits` out 4*`NDIG`: nibble i = digit i value.
- `out_err` out `NDIG`: bit i = digit i pattern was not decodable.
- `out_ovf` out 1: sticky flag; at least one completed frame was dropped.

## Operation
- **Input stage:** `{seg_i, an_i}` is registered every cycle into `smp`.
- **Stability counter `cnt`:**
  - If `smp` differs from the previous `smp`, `cnt` clears to 0.
  - Otherwise `cnt` increments, saturating at `STABLE`-1.
  - A commit fires exactly once per stable run, on the increment to `STABLE`-1.
- **Commit with a valid strobe** (`an` has exactly one 0 bit at index i):
  - Decode `seg` and write value and error into slot i.
  - Set `seen[i]`.
  - Rewriting a slot before the frame completes overwrites it; `seen` stays set.
- **Commit with an invalid strobe** (zero or several digits low): ignored. No write, `seen` unchanged.
- **Decode:**
  - Patterns 0–9 map to 0–9 with err=0.
  - All segments dark maps to value 0 with err=1.
  - Any other pattern maps to value 0 with err=1 (A–F: see Configuration).
- **Frame completion:** when a commit makes `seen` all ones, `seen` clears. Then:
  - If `out_valid`=0, or `out_ready`=1 in the same cycle: load `out_digits`/`out_err` and set `out_valid`=1.
  - Otherwise: drop the frame and set `out_ovf`.
- **Handshake:**
  - Transfer happens on a cycle with `out_valid` & `out_ready`.
  - `out_valid` drops after the transfer unless a frame loads in the same cycle; in that case it stays 1 with the new data.
  - Outputs are held stable while `out_valid`=1 and `out_ready`=0.
  - `out_ovf` clears on a transfer; it is set instead if a frame is dropped in that same cycle.
- **Reset** (`rst`=1 for one edge, any time, including mid-frame):
  - `smp` = all ones; `cnt`=0; `seen`=0.
  - `out_valid`=0, `out_digits`=0, `out_err`=0, `out_ovf`=0.
  - Partial frames are discarded.

## Timing
- A pattern first present at `seg_i`/`an_i` before edge k is sampled at edge k and committed at edge k+`STABLE`-1.
- A last-digit commit makes `out_valid` visible after that same edge (latency `STABLE` cycles from input).
- No combinational path from `seg_i`/`an_i` to any output.
- `out_ready` affects state only on the next edge. There is no combinational `out_ready`→`out_valid` path.
- Glitches shorter than `STABLE` samples never commit.

## Configuration
- Macro `SEG7_HEX_EN`.
- **Defined:** patterns A, b, C, d, E, F (active-low codes matching the shared package constants) decode to 10–15 with err=0.
- **Undefined:** those patterns decode to value 0 with err=1.
- Nothing else changes.

## Structure
- **Package `seg7_pkg`:**
  - Segment-pattern constants `SEG7_0`..`SEG7_F` and `SEG7_BLANK`, all 7-bit active-low.
  - Localparam for digit nibble width (4).
  - Shared with the display-driver side.
- **Sub-module `seg7_pattern_decode`:** combinational, 7-bit pattern in, 4-bit value + err out. Honours `SEG7_HEX_EN`.
- **Top level:** sampling, `cnt`, one-hot check, `seen`, frame registers and handshake.

## Test plan
- **Full frame:** NDIG=8, STABLE=4, `out_ready`=1. Drive digits 0..7 with correct patterns, each held 6 cycles.
  - Expect `out_valid` pulse with `out_digits`=32'h76543210 and `out_err`=0.
- **Glitch rejection:** hold digit 3's pattern for 3 cycles, then a stable one for 4.
  - Expect only the stable value in slot 3.
- **Invalid strobe:** `an_i`=8'hFF, then 8'b11110011, each held 8 cycles.
  - Expect no commits and `seen` unchanged; frame still completes later.
- **Backpressure / overflow:** `out_ready`=0, complete two frames.
  - Expect the first frame held, `out_ovf`=1.
  - Raise `out_ready` for 1 cycle: transfer, `out_ovf`=0.
- **Hex and error:** drive pattern "A" on digit 0 and blank on digit 1.
  - With `SEG7_HEX_EN`: nibble0=4'hA, `out_err`[0]=0. Without it: nibble0=0, `out_err`[0]=1.
  - Both builds: `out_err`[1]=1.
- **Reset mid-frame:** commit digits 0–4, pulse `rst`.
  - Expect all outputs 0; after a reset, a new frame needs all 8 digits before `out_valid`.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared seven-segment constants (active-low, bit0 = a .. bit6 = g).
// Used by both the display-driver side and the scan decoder.
package seg7_pkg;

    localparam int NIB_W = 4;

    localparam logic [6:0] SEG7_0     = 7'h40;
    localparam logic [6:0] SEG7_1     = 7'h79;
    localparam logic [6:0] SEG7_2     = 7'h24;
    localparam logic [6:0] SEG7_3     = 7'h30;
    localparam logic [6:0] SEG7_4     = 7'h19;
    localparam logic [6:0] SEG7_5     = 7'h12;
    localparam logic [6:0] SEG7_6     = 7'h02;
    localparam logic [6:0] SEG7_7     = 7'h78;
    localparam logic [6:0] SEG7_8     = 7'h00;
    localparam logic [6:0] SEG7_9     = 7'h10;
    localparam logic [6:0] SEG7_A     = 7'h08;
    localparam logic [6:0] SEG7_B     = 7'h03;
    localparam logic [6:0] SEG7_C     = 7'h46;
    localparam logic [6:0] SEG7_D     = 7'h21;
    localparam logic [6:0] SEG7_E     = 7'h06;
    localparam logic [6:0] SEG7_F     = 7'h0E;
    localparam logic [6:0] SEG7_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Frame output bus of the scan decoder: valid/ready plus frame payload.
// The decoder is the master; the consumer is the slave.
interface seg7_scan_decoder_if #(
    parameter int NDIG = 8
);
    import seg7_pkg::*;

    logic                    out_valid;
    logic                    out_ready;
    logic [NIB_W*NDIG-1:0]   out_digits;
    logic [NDIG-1:0]         out_err;
    logic                    out_ovf;

    modport master (
        output out_valid,
        output out_digits,
        output out_err,
        output out_ovf,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_digits,
        input  out_err,
        input  out_ovf,
        output out_ready
    );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Active-low 7-segment pattern to 4-bit value; err flags undecodable codes.
// Hex letters A..F decode only when SEG7_HEX_EN is defined.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0]       pattern,
    output logic [NIB_W-1:0] value,
    output logic             err
);

    // Table lookup; anything unlisted (including blank) is an error.
    always_comb begin
        value = '0;
        err   = 1'b0;
        case (pattern)
            SEG7_0: value = 4'd0;
            SEG7_1: value = 4'd1;
            SEG7_2: value = 4'd2;
            SEG7_3: value = 4'd3;
            SEG7_4: value = 4'd4;
            SEG7_5: value = 4'd5;
            SEG7_6: value = 4'd6;
            SEG7_7: value = 4'd7;
            SEG7_8: value = 4'd8;
            SEG7_9: value = 4'd9;
`ifdef SEG7_HEX_EN
            SEG7_A: value = 4'd10;
            SEG7_B: value = 4'd11;
            SEG7_C: value = 4'd12;
            SEG7_D: value = 4'd13;
            SEG7_E: value = 4'd14;
            SEG7_F: value = 4'd15;
`endif
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 7-seg bus, debounces, decodes and assembles frames.
// Optional hex-letter decode via macro SEG7_HEX_EN (see seg7_pattern_decode).
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG   = 8,
    parameter int STABLE = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      seg_i,
    input  logic [NDIG-1:0] an_i,
    seg7_scan_decoder_if.master out
);

    localparam int SW = 7 + NDIG;
    localparam logic [3:0] CNT_MAX = 4'(STABLE - 1);
    localparam logic [3:0] CNT_PRE = 4'(STABLE - 2);

    logic [SW-1:0] smp;
    logic [SW-1:0] din;
    logic [3:0]    cnt;
    logic          same;
    logic          commit;

    logic [NDIG-1:0] hot;
    logic            strobe_ok;
    logic            wr;

    logic [NIB_W-1:0] dec_val;
    logic             dec_err;

    logic [NDIG-1:0][NIB_W-1:0] slot_val;
    logic [NDIG-1:0][NIB_W-1:0] slot_val_n;
    logic [NDIG-1:0]            slot_err;
    logic [NDIG-1:0]            slot_err_n;
    logic [NDIG-1:0]            seen;
    logic [NDIG-1:0]            seen_n;

    logic done;
    logic xfer;
    logic load;
    logic drop;

    logic                       valid_q;
    logic [NDIG-1:0][NIB_W-1:0] digits_q;
    logic [NDIG-1:0]            err_q;
    logic                       ovf_q;

    assign din    = {seg_i, an_i};
    assign same   = (din == smp);
    assign commit = same && (cnt == CNT_PRE);

    // Input sample register and stability run counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp <= '1;
            cnt <= '0;
        end else begin
            smp <= din;
            if (!same)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 4'd1;
        end
    end

    seg7_pattern_decode u_dec (
        .pattern (smp[SW-1:NDIG]),
        .value   (dec_val),
        .err     (dec_err)
    );

    // Strobe must be exactly one digit low to address a slot.
    always_comb begin
        hot       = ~smp[NDIG-1:0];
        strobe_ok = (hot != '0) && ((hot & (hot - 1'b1)) == '0);
        wr        = commit && strobe_ok;
    end

    // Next slot contents and seen mask after this commit.
    always_comb begin
        slot_val_n = slot_val;
        slot_err_n = slot_err;
        seen_n     = seen;
        for (int i = 0; i < NDIG; i++) begin
            if (wr && hot[i]) begin
                slot_val_n[i] = dec_val;
                slot_err_n[i] = dec_err;
                seen_n[i]     = 1'b1;
            end
        end
        done = wr && (&seen_n);
    end

    // Frame load vs. drop decision against the output handshake.
    always_comb begin
        xfer = valid_q && out.out_ready;
        load = done && (!valid_q || out.out_ready);
        drop = done && valid_q && !out.out_ready;
    end

    // Slot storage and partial-frame tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_val <= '0;
            slot_err <= '0;
            seen     <= '0;
        end else begin
            slot_val <= slot_val_n;
            slot_err <= slot_err_n;
            seen     <= done ? '0 : seen_n;
        end
    end

    // Output frame register, valid flag and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            digits_q <= '0;
            err_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (load) begin
                valid_q  <= 1'b1;
                digits_q <= slot_val_n;
                err_q    <= slot_err_n;
            end else if (xfer) begin
                valid_q <= 1'b0;
            end
            if (drop)
                ovf_q <= 1'b1;
            else if (xfer)
                ovf_q <= 1'b0;
        end
    end

    assign out.out_valid  = valid_q;
    assign out.out_digits = digits_q;
    assign out.out_err    = err_q;
    assign out.out_ovf    = ovf_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder (NDIG=8, STABLE=4).
// Expected frames are queued on stimulus and popped on each transfer.
module tb_seg7_scan_decoder;

    localparam int NDIG   = 8;
    localparam int STABLE = 4;

    typedef struct packed {
        logic [7:0][6:0] pats;
        logic [31:0]     digits;
        logic [7:0]      err;
    } vec_t;

    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  err;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [6:0]      seg_i;
    logic [NDIG-1:0] an_i;

    int checks = 0;
    int passed = 0;
    exp_t sb[$];
    vec_t tbl[4];

    seg7_scan_decoder_if #(.NDIG(NDIG)) bus ();

    seg7_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk   (clk),
        .rst   (rst),
        .seg_i (seg_i),
        .an_i  (an_i),
        .out   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] code(int v);
        case (v)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act === req)
            passed++;
        else
            $display("FAIL %s: got %h want %h", name, act, req);
    endtask

    task automatic drive(logic [6:0] p, logic [7:0] an, int n);
        seg_i = p;
        an_i  = an;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic dig(int slot, int v);
        drive(code(v), ~(8'(1) << slot), 6);
    endtask

    task automatic push(logic [31:0] d, logic [7:0] e);
        exp_t x;
        x.digits = d;
        x.err    = e;
        sb.push_back(x);
    endtask

    // Scoreboard: compare each transferred frame against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_frame: got %h want none",
                         bus.out_digits);
            end else begin
                e = sb.pop_front();
                check("frame_digits", bus.out_digits, e.digits);
                check("frame_err", 32'(bus.out_err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[0].pats[i] = code(i);
            tbl[1].pats[i] = code(9 - i);
            tbl[2].pats[i] = code(5);
            tbl[3].pats[i] = code(i);
        end
        tbl[0].digits = 32'h76543210;
        tbl[0].err    = 8'h00;
        tbl[1].digits = 32'h23456789;
        tbl[1].err    = 8'h00;
        tbl[2].pats[0] = code(10);
        tbl[2].pats[1] = 7'h7F;
`ifdef SEG7_HEX_EN
        tbl[2].digits = 32'h5555550A;
        tbl[2].err    = 8'h02;
`else
        tbl[2].digits = 32'h55555500;
        tbl[2].err    = 8'h03;
`endif
        tbl[3].pats[0] = code(3);
        tbl[3].pats[1] = code(1);
        tbl[3].pats[2] = code(4);
        tbl[3].pats[3] = code(1);
        tbl[3].pats[4] = code(5);
        tbl[3].pats[5] = code(9);
        tbl[3].pats[6] = code(2);
        tbl[3].pats[7] = 7'h7E;
        tbl[3].digits  = 32'h02951413;
        tbl[3].err     = 8'h80;

        rst   = 1'b1;
        seg_i = '1;
        an_i  = '1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_digits", bus.out_digits, 0);
        check("rst_err", 32'(bus.out_err), 0);
        check("rst_ovf", 32'(bus.out_ovf), 0);
        @(posedge clk);
        #1;

        for (int v = 0; v < 4; v++) begin
            push(tbl[v].digits, tbl[v].err);
            for (int i = 0; i < 8; i++)
                drive(tbl[v].pats[i], ~(8'(1) << i), 6);
        end

        push(32'h76543210, 8'h00);
        for (int i = 0; i < 3; i++) dig(i, i);
        drive(code(9), 8'b11110111, 3);
        drive(code(3), 8'b11110111, 4);
        for (int i = 4; i < 8; i++) dig(i, i);

        push(32'h76543210, 8'h00);
        for (int i = 0; i < 4; i++) dig(i, i);
        drive(code(8), 8'hFF, 8);
        drive(code(8), 8'b11110011, 8);
        @(negedge clk);
        check("invalid_no_frame", 32'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        for (int i = 4; i < 7; i++) dig(i, i);
        @(negedge clk);
        check("partial_no_frame", 32'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        dig(7, 7);

        bus.out_ready = 1'b0;
        push(32'h76543210, 8'h00);
        for (int i = 0; i < 8; i++) dig(i, i);
        for (int i = 0; i < 8; i++) dig(i, 9 - i);
        @(negedge clk);
        check("bp_valid", 32'(bus.out_valid), 1);
        check("bp_held", bus.out_digits, 32'h76543210);
        check("bp_ovf", 32'(bus.out_ovf), 1);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_after_valid", 32'(bus.out_valid), 0);
        check("bp_after_ovf", 32'(bus.out_ovf), 0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;

        for (int i = 0; i < 5; i++) dig(i, 9);
        an_i = '1;
        rst  = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        check("mid_rst_digits", bus.out_digits, 0);
        check("mid_rst_err", 32'(bus.out_err), 0);
        check("mid_rst_ovf", 32'(bus.out_ovf), 0);
        @(posedge clk);
        #1;
        for (int i = 5; i < 8; i++) dig(i, i);
        push(32'h76543210, 8'h00);
        for (int i = 0; i < 5; i++) dig(i, i);

        repeat (10) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
